booth_mult32: RTL
=================

# booth_mult32

- Iterative signed 32×32 multiplier using radix-2 Booth recoding.
- Reuses the existing 32-bit carry-select adder (`Adder32`) as its only arithmetic datapath: one add or subtract plus one arithmetic shift per cycle.
- Sits beside the ALU in the execute stage. Issue logic pulses `start`; the block produces a 64-bit product, an overflow flag and a one-cycle `ready` pulse after a fixed 33-cycle latency.

## Interface
- `WIDTH`, default 32: operand width. Fixed at 32 because the adder instance is 32-bit; the parameter exists only for the package constant.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply. Sampled only in IDLE or DONE.
- `operand_a` in 32: multiplicand M, two's complement.
- `operand_b` in 32: multiplier Q, two's complement.
- `product_lo` out 32: low word of the product. Registered.
- `product_hi` out 32: high word of the product. Registered.
- `exception` out 1: 1 when the 64-bit product does not fit in signed 32 bits.
- `ready` out 1: one-cycle pulse marking the cycle in which results first become valid.
- `busy` out 1: high while in RUN.

## Operation
- **State registers:**
  - M (32).
  - P (65) = {A[31:0], Q[31:0], q_m1}.
  - 6-bit iteration counter.
  - 2-bit state.
- **States:** IDLE, RUN, DONE.
- **IDLE/DONE, `start`=1:**
  - Load M←`operand_a` and P←{32'b0, `operand_b`, 1'b0}.
  - Counter←0. Go to RUN.
  - Outputs keep their previous values.
- **RUN, each cycle:** select the adder inputs from {P[1], P[0]}:
  - 01: b = M, c_in = 0.
  - 10: b = ~M, c_in = 1.
  - 00 or 11: b = 0, c_in = 0.
  - The adder always takes a = P[64:33].
- **True sign of the sum** = a[31] ^ b[31] ^ c_out. This handles M = 0x80000000 without a 33rd bit.
- **P update:** P ← {true_sign, sum, P[32:1]}, i.e. an arithmetic right shift of {sum, Q, q_m1}.
- **Counter:** increments each RUN cycle. On the 32nd RUN cycle (counter == 31), go to DONE.
- **Entering DONE:**
  - `product_hi`←new P[64:33], `product_lo`←new P[32:1].
  - `exception`←(`product_hi` != {32{`product_lo`[31]}}).
  - `ready`=1 for that cycle only.
- **DONE without `start`:** stay in DONE; outputs hold and `ready`=0.
- **`start` during RUN:** ignored. The running operation completes unchanged.
- **Operands** are captured at `start` only. Later changes on the inputs have no effect.
- **Reset** (`reset_n`=0, any time, including mid-RUN):
  - State←IDLE, counter←0, M and P cleared.
  - `product_lo`, `product_hi`, `exception`, `ready`, `busy` all ←0 immediately.
  - The aborted operation never raises `ready`.

## Timing
- **Cycle 0:** `start` sampled. RUN begins at cycle 1, and `busy`=1 during cycles 1–32.
- **Cycle 33** (registered at the end of RUN cycle 32): `ready`=1, and `product_lo`, `product_hi`, `exception` are valid.
- **Latency** = 33 cycles from the `start` edge to `ready`.
- **Throughput:**
  - A new `start` is accepted in the same cycle `ready` is high (DONE accepts `start`).
  - Back-to-back issue therefore costs 33 cycles per multiply.
- **Combinational path per cycle:** one `Adder32` plus a 3:1 mux. No other arithmetic.
- **Register vs. output reset:** `ready` and `busy` derive from registered state only. `busy` and `ready` are 0 in reset.

## Structure
- **Shared package:**
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - `WIDTH`=32.
  - `ITERATIONS`=32.
  - Booth select codes (ADD, SUB, NOP).
- **One sub-module:** the existing `Adder32`, instantiated once.
  - Booth select, shift and counter logic stay in `booth_mult32`.
  - No separate control module; the FSM is small.

## Test plan
- **Small positive:** `operand_a`=3, `operand_b`=5, `start` → at cycle 33 `ready`=1, {hi,lo} = 0x00000000_0000000F, `exception`=0.
- **Mixed sign:** −7 (0xFFFFFFF9) × 6 → lo=0xFFFFFFD6, hi=0xFFFFFFFF, `exception`=0.
- **Overflow:** 0x7FFFFFFF × 2 → lo=0xFFFFFFFE, hi=0x00000000, `exception`=1.
- **Most-negative edge:** 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000, `exception`=1. This exercises the true-sign path.
- **`start` during RUN:** pulse `start` with 2×2 at cycle 10 of a 3×5 operation → result 15 at cycle 33, single `ready` pulse. A new `start` at cycle 33 then yields 4 at cycle 66.
- **Reset mid-RUN:** assert `reset_n`=0 at cycle 15 → all outputs 0 immediately, no `ready` pulse. After release, `start` 9 × −1 → lo=0xFFFFFFF7 after 33 cycles.

Source files
------------

// File: rtl/booth_mult32_pkg.sv
// Shared constants, FSM state encoding and Booth select codes for booth_mult32.
package booth_mult32_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_NOP = 2'd0,
        SEL_ADD = 2'd1,
        SEL_SUB = 2'd2
    } booth_sel_e;

    // Radix-2 Booth recoding of the pair {Q[0], q_m1}.
    function automatic booth_sel_e booth_select(input logic [1:0] pair);
        booth_sel_e sel;
        case (pair)
            2'b01:   sel = SEL_ADD;
            2'b10:   sel = SEL_SUB;
            default: sel = SEL_NOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_mult32_adder32.sv
// 32-bit carry-select adder: four 8-bit blocks, each precomputing both carry-in cases.
// Purely combinational; no handshake.
module Adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_in_i,
    output logic [31:0] sum_o,
    output logic        c_out_o
);

    localparam int BLK  = 8;
    localparam int NBLK = 4;

    logic [NBLK:0] carry;

    assign carry[0] = c_in_i;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] sum_c0;
        logic [BLK:0] sum_c1;

        assign sum_c0 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]};
        assign sum_c1 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]} + (BLK+1)'(1);

        assign sum_o[g*BLK +: BLK] = carry[g] ? sum_c1[BLK-1:0] : sum_c0[BLK-1:0];
        assign carry[g+1]          = carry[g] ? sum_c1[BLK]     : sum_c0[BLK];
    end

    assign c_out_o = carry[NBLK];

endmodule

// File: rtl/booth_mult32.sv
// Iterative signed 32x32 radix-2 Booth multiplier: one add/sub + arithmetic shift per cycle.
// Latency 33 cycles start->ready; start is ignored while busy, accepted again in the ready cycle.
module booth_mult32 #(
    parameter int WIDTH = booth_mult32_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             exception,
    output logic             ready,
    output logic             busy
);

    import booth_mult32_pkg::*;

    localparam int PW = 2*WIDTH + 1;

    state_e             state_q;
    logic [WIDTH-1:0]   m_q;
    logic [PW-1:0]      p_q;
    logic [PW-1:0]      p_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   product_lo_q;
    logic [WIDTH-1:0]   product_hi_q;
    logic               exception_q;
    logic               ready_q;
    logic               busy_q;

    booth_sel_e         sel;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cin;
    logic               add_cout;
    logic               true_sign;
    logic               last_iter;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_exc;

    always_comb begin
        sel     = booth_select(p_q[1:0]);
        add_b   = '0;
        add_cin = 1'b0;
        case (sel)
            SEL_ADD: add_b = m_q;
            SEL_SUB: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_a = p_q[PW-1 -: WIDTH];

    Adder32 u_adder (
        .a_i     (add_a),
        .b_i     (add_b),
        .c_in_i  (add_cin),
        .sum_o   (add_sum),
        .c_out_o (add_cout)
    );

    // Sign of the 33-bit sum without a 33rd adder bit; keeps M = 0x80000000 correct.
    assign true_sign = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
    assign p_d       = {true_sign, add_sum, p_q[WIDTH:1]};
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign last_iter = (cnt_q == CNT_W'(ITERATIONS-1));

    assign res_hi  = p_d[PW-1 -: WIDTH];
    assign res_lo  = p_d[WIDTH:1];
    assign res_exc = (res_hi != {WIDTH{res_lo[WIDTH-1]}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            m_q          <= '0;
            p_q          <= '0;
            cnt_q        <= '0;
            product_lo_q <= '0;
            product_hi_q <= '0;
            exception_q  <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        m_q     <= operand_a;
                        p_q     <= {{WIDTH{1'b0}}, operand_b, 1'b0};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_d;
                    if (last_iter) begin
                        product_hi_q <= res_hi;
                        product_lo_q <= res_lo;
                        exception_q  <= res_exc;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign product_lo = product_lo_q;
    assign product_hi = product_hi_q;
    assign exception  = exception_q;
    assign ready      = ready_q;
    assign busy       = busy_q;

endmodule
